// File: rtl/display_timings.sv
// Parametrised raster timing generator: pixel-enabled sx/sy counters with
// registered sync/DE aligned to the position, line/frame strobes and a frame counter.
module display_timings #(
    parameter int unsigned CORDW  = 10,
    parameter int unsigned H_RES  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter bit          H_POL  = 1'b0,
    parameter bit          V_POL  = 1'b0,
    parameter int unsigned FRAMEW = 16
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              ce,
    output logic [CORDW-1:0]  sx,
    output logic [CORDW-1:0]  sy,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              line,
    output logic              frame,
    output logic [FRAMEW-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL  = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_RES + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_RES + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_RES + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [CORDW-1:0] H_LAST  = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST  = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT   = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT   = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_LO   = CORDW'(HS_START);
    localparam logic [CORDW-1:0] HS_HI   = CORDW'(HS_END);
    localparam logic [CORDW-1:0] VS_LO   = CORDW'(VS_START);
    localparam logic [CORDW-1:0] VS_HI   = CORDW'(VS_END);

    logic [CORDW-1:0]  sx_q, sx_d;
    logic [CORDW-1:0]  sy_q, sy_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              de_q, de_d;
    logic              line_q, line_d;
    logic              frame_q, frame_d;
    logic [FRAMEW-1:0] frame_cnt_q, frame_cnt_d;

    // Next position plus sync/DE decoded from it, so they register together.
    always_comb begin
        sx_d        = sx_q;
        sy_d        = sy_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        de_d        = de_q;
        line_d      = 1'b0;
        frame_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (ce) begin
            if (sx_q == H_LAST) begin
                sx_d = '0;
                sy_d = (sy_q == V_LAST) ? '0 : sy_q + CORDW'(1);
            end else begin
                sx_d = sx_q + CORDW'(1);
            end
            hsync_d = ((sx_d >= HS_LO) && (sx_d < HS_HI)) ? H_POL : ~H_POL;
            vsync_d = ((sy_d >= VS_LO) && (sy_d < VS_HI)) ? V_POL : ~V_POL;
            de_d    = (sx_d < H_ACT) && (sy_d < V_ACT);
            line_d  = (sx_d == '0);
            frame_d = (sx_d == '0) && (sy_d == '0);
            if (frame_d) begin
                frame_cnt_d = frame_cnt_q + FRAMEW'(1);
            end
        end
    end

    // Reset parks on the last position so the first enabled edge starts frame 0.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            sx_q        <= H_LAST;
            sy_q        <= V_LAST;
            hsync_q     <= ~H_POL;
            vsync_q     <= ~V_POL;
            de_q        <= 1'b0;
            line_q      <= 1'b0;
            frame_q     <= 1'b0;
            frame_cnt_q <= '1;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            line_q      <= line_d;
            frame_q     <= frame_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign sx        = sx_q;
    assign sy        = sy_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign line      = line_q;
    assign frame     = frame_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_display_timings.sv
// Directed bench for display_timings: default 640x480 instance and a tiny
// 8x6 positive-sync instance with a 2-bit frame counter.
module tb_display_timings;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        df_rst, df_ce;
    logic [9:0]  df_sx, df_sy;
    logic        df_hs, df_vs, df_de, df_ln, df_fr;
    logic [15:0] df_fc;

    logic        sm_rst, sm_ce;
    logic [3:0]  sm_sx, sm_sy;
    logic        sm_hs, sm_vs, sm_de, sm_ln, sm_fr;
    logic [1:0]  sm_fc;

    display_timings u_def (
        .clk_pix(clk), .rst_pix(df_rst), .ce(df_ce),
        .sx(df_sx), .sy(df_sy), .hsync(df_hs), .vsync(df_vs), .de(df_de),
        .line(df_ln), .frame(df_fr), .frame_cnt(df_fc)
    );

    display_timings #(
        .CORDW(4), .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .FRAMEW(2)
    ) u_sml (
        .clk_pix(clk), .rst_pix(sm_rst), .ce(sm_ce),
        .sx(sm_sx), .sy(sm_sy), .hsync(sm_hs), .vsync(sm_vs), .de(sm_de),
        .line(sm_ln), .frame(sm_fr), .frame_cnt(sm_fc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset held with ce high: reset values, no strobes.
    task automatic test_reset();
        df_rst = 1'b1; df_ce = 1'b1;
        sm_rst = 1'b1; sm_ce = 1'b1;
        step(); step();
        checks++;
        if ({df_sx, df_sy} !== {10'd799, 10'd524}) begin
            errors++; $display("FAIL reset_pos_def: got sx=%0d sy=%0d want 799 524", df_sx, df_sy);
        end
        checks++;
        if ({df_de, df_hs, df_vs, df_ln, df_fr} !== 5'b01100) begin
            errors++; $display("FAIL reset_flags_def: got de,hs,vs,ln,fr=%b want 01100", {df_de, df_hs, df_vs, df_ln, df_fr});
        end
        checks++;
        if (df_fc !== 16'hFFFF) begin
            errors++; $display("FAIL reset_fcnt_def: got %h want ffff", df_fc);
        end
        checks++;
        if ({sm_sx, sm_sy, sm_de, sm_hs, sm_vs, sm_ln, sm_fr, sm_fc} !== {4'd7, 4'd5, 5'b00000, 2'b11}) begin
            errors++; $display("FAIL reset_small: got sx=%0d sy=%0d de,hs,vs,ln,fr=%b fc=%0d want 7 5 00000 3",
                               sm_sx, sm_sy, {sm_de, sm_hs, sm_vs, sm_ln, sm_fr}, sm_fc);
        end
    endtask

    // First enabled edge after reset lands on (0,0) and starts frame 0.
    task automatic test_first_edge();
        df_rst = 1'b0;
        step();
        checks++;
        if ({df_sx, df_sy, df_ln, df_fr} !== {10'd0, 10'd0, 2'b11}) begin
            errors++; $display("FAIL first_edge: got sx=%0d sy=%0d ln=%b fr=%b want 0 0 1 1", df_sx, df_sy, df_ln, df_fr);
        end
        checks++;
        if ({df_fc, df_de, df_hs, df_vs} !== {16'd0, 3'b111}) begin
            errors++; $display("FAIL first_edge_out: got fc=%0d de,hs,vs=%b want 0 111", df_fc, {df_de, df_hs, df_vs});
        end
        step();
        checks++;
        if ({df_sx, df_ln, df_fr} !== {10'd1, 2'b00}) begin
            errors++; $display("FAIL strobe_width: got sx=%0d ln=%b fr=%b want 1 0 0", df_sx, df_ln, df_fr);
        end
    endtask

    // Three full lines at ce=1: hsync window, DE count, line period.
    task automatic test_line_timing();
        int hs_bad = 0, hs_low = 0, de_cnt = 0, n_line = 0, per_bad = 0, last_t = -1, sx_max = 0, vs_bad = 0, fr_cnt = 0;
        logic exp_hs;
        df_ce = 1'b1;
        for (int i = 1; i <= 2400; i++) begin
            step();
            exp_hs = !((df_sx >= 10'd656) && (df_sx <= 10'd751));
            if (df_hs !== exp_hs) hs_bad++;
            if (df_hs == 1'b0) hs_low++;
            if (df_vs !== 1'b1) vs_bad++;
            if (df_de) de_cnt++;
            if (df_fr) fr_cnt++;
            if (int'(df_sx) > sx_max) sx_max = int'(df_sx);
            if (df_ln) begin
                if (df_sx !== 10'd0) per_bad++;
                if (last_t >= 0 && (i - last_t) != 800) per_bad++;
                last_t = i;
                n_line++;
            end
        end
        checks++;
        if (hs_bad != 0) begin errors++; $display("FAIL hsync_window: got %0d bad cycles want 0", hs_bad); end
        checks++;
        if (hs_low != 288) begin errors++; $display("FAIL hsync_width: got %0d low cycles want 288", hs_low); end
        checks++;
        if (de_cnt != 1920) begin errors++; $display("FAIL de_count: got %0d want 1920", de_cnt); end
        checks++;
        if (n_line != 3 || per_bad != 0) begin
            errors++; $display("FAIL line_period: got %0d strobes %0d bad want 3 0", n_line, per_bad);
        end
        checks++;
        if (sx_max != 799 || vs_bad != 0 || fr_cnt != 0) begin
            errors++; $display("FAIL line_misc: got sx_max=%0d vs_bad=%0d frames=%0d want 799 0 0", sx_max, vs_bad, fr_cnt);
        end
        checks++;
        if ({df_sx, df_sy} !== {10'd1, 10'd3}) begin
            errors++; $display("FAIL line_end_pos: got sx=%0d sy=%0d want 1 3", df_sx, df_sy);
        end
    endtask

    // ce toggling: hold while low, advance while high, line period doubles.
    task automatic test_ce_toggle();
        int hold_bad = 0, adv_bad = 0, n_line = 0, t0 = -1, t1 = -1;
        logic [9:0] p_sx, p_sy;
        logic p_hs, p_vs, p_de;
        logic [15:0] p_fc;
        logic was_ce;
        for (int i = 0; i < 3200; i++) begin
            df_ce = (i % 2 == 1);
            was_ce = df_ce;
            p_sx = df_sx; p_sy = df_sy; p_hs = df_hs; p_vs = df_vs; p_de = df_de; p_fc = df_fc;
            step();
            if (!was_ce) begin
                if ({df_sx, df_sy, df_hs, df_vs, df_de, df_fc, df_ln, df_fr} !== {p_sx, p_sy, p_hs, p_vs, p_de, p_fc, 2'b00})
                    hold_bad++;
            end else begin
                if (p_sx == 10'd799) begin
                    if (df_sx !== 10'd0 || df_sy !== p_sy + 10'd1) adv_bad++;
                end else if (df_sx !== p_sx + 10'd1 || df_sy !== p_sy) begin
                    adv_bad++;
                end
            end
            if (df_ln) begin
                if (n_line == 0) t0 = i; else t1 = i;
                n_line++;
            end
        end
        checks++;
        if (hold_bad != 0) begin errors++; $display("FAIL ce_hold: got %0d bad cycles want 0", hold_bad); end
        checks++;
        if (adv_bad != 0) begin errors++; $display("FAIL ce_advance: got %0d bad cycles want 0", adv_bad); end
        checks++;
        if (n_line != 2 || (t1 - t0) != 1600) begin
            errors++; $display("FAIL ce_line_period: got %0d strobes period %0d want 2 1600", n_line, t1 - t0);
        end
        checks++;
        if ({df_sx, df_sy} !== {10'd1, 10'd5}) begin
            errors++; $display("FAIL ce_end_pos: got sx=%0d sy=%0d want 1 5", df_sx, df_sy);
        end
    endtask

    // One-cycle reset mid-frame, then restart at frame 0.
    task automatic test_midframe_reset();
        int n = 0;
        df_ce = 1'b1;
        while (!(df_sx == 10'd300 && df_sy == 10'd6) && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (n >= 2000) begin errors++; $display("FAIL mid_reset_reach: position 300,6 not reached, at %0d,%0d", df_sx, df_sy); end
        checks++;
        if (df_fc !== 16'd0) begin errors++; $display("FAIL mid_reset_prefc: got %0d want 0", df_fc); end
        df_rst = 1'b1;
        step();
        checks++;
        if ({df_sx, df_sy, df_de, df_hs, df_vs, df_ln, df_fr, df_fc} !== {10'd799, 10'd524, 5'b01100, 16'hFFFF}) begin
            errors++; $display("FAIL mid_reset_state: got sx=%0d sy=%0d de,hs,vs,ln,fr=%b fc=%h want 799 524 01100 ffff",
                               df_sx, df_sy, {df_de, df_hs, df_vs, df_ln, df_fr}, df_fc);
        end
        df_rst = 1'b0;
        step();
        checks++;
        if ({df_sx, df_sy, df_ln, df_fr, df_fc} !== {10'd0, 10'd0, 2'b11, 16'd0}) begin
            errors++; $display("FAIL mid_reset_restart: got sx=%0d sy=%0d ln=%b fr=%b fc=%0d want 0 0 1 1 0",
                               df_sx, df_sy, df_ln, df_fr, df_fc);
        end
    endtask

    // Tiny geometry: sync windows, DE, 48-clk frame, 2-bit frame counter wrap.
    task automatic test_small_geometry();
        int win_bad = 0, vs_edge_bad = 0, hs_hi = 0, vs_hi = 0, de_cnt = 0, n_line = 0, n_frame = 0, fr_bad = 0, sx_max = 0, sy_max = 0;
        logic [1:0] exp_fc [4];
        logic p_vs;
        exp_fc[0] = 2'd1; exp_fc[1] = 2'd2; exp_fc[2] = 2'd3; exp_fc[3] = 2'd0;
        sm_rst = 1'b0; sm_ce = 1'b1;
        step();
        checks++;
        if ({sm_sx, sm_sy, sm_fr, sm_ln, sm_fc, sm_de, sm_hs, sm_vs} !== {4'd0, 4'd0, 2'b11, 2'd0, 3'b100}) begin
            errors++; $display("FAIL small_first: got sx=%0d sy=%0d fr=%b fc=%0d de,hs,vs=%b want 0 0 1 0 100",
                               sm_sx, sm_sy, sm_fr, sm_fc, {sm_de, sm_hs, sm_vs});
        end
        for (int i = 1; i <= 240; i++) begin
            p_vs = sm_vs;
            step();
            if (sm_hs !== (sm_sx == 4'd5 || sm_sx == 4'd6)) win_bad++;
            if (sm_vs !== (sm_sy == 4'd4)) win_bad++;
            if (sm_de !== (sm_sx < 4'd4 && sm_sy < 4'd3)) win_bad++;
            if (sm_vs !== p_vs && sm_sx !== 4'd0) vs_edge_bad++;
            if (sm_hs) hs_hi++;
            if (sm_vs) vs_hi++;
            if (sm_de) de_cnt++;
            if (sm_ln) n_line++;
            if (int'(sm_sx) > sx_max) sx_max = int'(sm_sx);
            if (int'(sm_sy) > sy_max) sy_max = int'(sm_sy);
            if (sm_fr) begin
                if (i != 48 * (n_frame + 1)) fr_bad++;
                if (n_frame < 4 && sm_fc !== exp_fc[n_frame]) begin
                    checks++; errors++;
                    $display("FAIL small_fcnt_seq: strobe %0d got fc=%0d want %0d", n_frame + 1, sm_fc, exp_fc[n_frame]);
                end else if (n_frame < 4) begin
                    checks++;
                end
                n_frame++;
            end
        end
        checks++;
        if (win_bad != 0 || vs_edge_bad != 0) begin
            errors++; $display("FAIL small_windows: got %0d window bad %0d vsync edge bad want 0 0", win_bad, vs_edge_bad);
        end
        checks++;
        if (hs_hi != 60 || vs_hi != 40 || de_cnt != 60) begin
            errors++; $display("FAIL small_counts: got hs=%0d vs=%0d de=%0d want 60 40 60", hs_hi, vs_hi, de_cnt);
        end
        checks++;
        if (n_frame != 5 || fr_bad != 0 || n_line != 30) begin
            errors++; $display("FAIL small_frame_period: got frames=%0d bad=%0d lines=%0d want 5 0 30", n_frame, fr_bad, n_line);
        end
        checks++;
        if (sx_max != 7 || sy_max != 5) begin
            errors++; $display("FAIL small_max_pos: got sx_max=%0d sy_max=%0d want 7 5", sx_max, sy_max);
        end
    endtask

    // Tiny geometry with ce toggling: frame period 96 clks, strobe 1 clk wide.
    task automatic test_small_ce_toggle();
        int n_frame = 0, t0 = -1, t1 = -1, wide_bad = 0;
        logic p_fr = 1'b0;
        for (int i = 0; i < 250; i++) begin
            sm_ce = (i % 2 == 0);
            step();
            if (sm_fr && p_fr) wide_bad++;
            if (sm_fr) begin
                if (n_frame == 0) t0 = i; else if (n_frame == 1) t1 = i;
                n_frame++;
            end
            p_fr = sm_fr;
        end
        checks++;
        if (n_frame < 2 || (t1 - t0) != 96 || wide_bad != 0) begin
            errors++; $display("FAIL small_ce_period: got frames=%0d period=%0d wide=%0d want >=2 96 0", n_frame, t1 - t0, wide_bad);
        end
    endtask

    initial begin
        df_rst = 1'b1; df_ce = 1'b0;
        sm_rst = 1'b1; sm_ce = 1'b0;
        test_reset();
        test_first_edge();
        test_line_timing();
        test_ce_toggle();
        test_midframe_reset();
        test_small_geometry();
        test_small_ce_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
